// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM encoding, the
// data returned on a watchdog abort, and the fair-arbitration decision.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'h0;

    // last = 1 means m1 owned the bus most recently, so m0 wins a tie.
    function automatic arb_state_t arbitrate(input logic req0, input logic req1, input logic last);
        arb_state_t nxt;
        if (req0 && req1) nxt = last ? ARB_GNT0 : ARB_GNT1;
        else if (req0)    nxt = ARB_GNT0;
        else if (req1)    nxt = ARB_GNT1;
        else              nxt = ARB_IDLE;
        return nxt;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobed cycles without ACK and fires when the count
// reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic fire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count;

    // A real ACK in the firing cycle suppresses the abort.
    assign fire = (TIMEOUT_CYCLES != 0) && active && !ack && (count == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!active || ack || fire) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 arbiter: holds a grant for a master's whole CYC,
// alternates on contention, and aborts accesses the slave never acknowledges.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_o,
    output logic [31:0] m0_dat_i,
    output logic        m0_ack,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_o,
    output logic [31:0] m1_dat_i,
    output logic        m1_ack,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic        timeout,
    output logic [1:0]  arb_state
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       gnt0;
    logic       gnt1;
    logic       active;
    logic       fire;

    assign gnt0 = (state_q == ARB_GNT0);
    assign gnt1 = (state_q == ARB_GNT1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: state_d = arbitrate(m0_cyc, m1_cyc, last_q);
            ARB_GNT0: if (!m0_cyc) state_d = arbitrate(m0_cyc, m1_cyc, last_q);
            ARB_GNT1: if (!m1_cyc) state_d = arbitrate(m0_cyc, m1_cyc, last_q);
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == ARB_GNT0)      last_q <= 1'b0;
            else if (state_d == ARB_GNT1) last_q <= 1'b1;
        end
    end

    assign active = (gnt0 && m0_cyc && m0_stb) || (gnt1 && m1_cyc && m1_stb);

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (active),
        .ack    (s_ack),
        .fire   (fire)
    );

    // On a watchdog abort the slave sees CYC/STB low while the owner gets a synthetic ACK.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        if (gnt0) begin
            s_cyc   = m0_cyc && !fire;
            s_stb   = m0_stb && !fire;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_dat_o = m0_dat_o;
            m0_ack  = s_ack || fire;
        end else if (gnt1) begin
            s_cyc   = m1_cyc && !fire;
            s_stb   = m1_stb && !fire;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_dat_o = m1_dat_o;
            m1_ack  = s_ack || fire;
        end
    end

    assign m0_dat_i  = fire ? TIMEOUT_DATA : s_dat_i;
    assign m1_dat_i  = fire ? TIMEOUT_DATA : s_dat_i;
    assign grant     = {gnt1, gnt0};
    assign timeout   = fire;
    assign arb_state = state_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a table of per-cycle vectors plus hand-written
// sequences for the watchdog boundary and asynchronous reset.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m0_ack;
    logic [31:0] m0_adr, m0_dat_o, m0_dat_i;
    logic        m1_cyc, m1_stb, m1_we, m1_ack;
    logic [31:0] m1_adr, m1_dat_o, m1_dat_i;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [1:0]  grant;
    logic        timeout;
    logic [1:0]  arb_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_o(m0_dat_o), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_o(m1_dat_o), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
        .grant(grant), .timeout(timeout), .arb_state(arb_state)
    );

    typedef struct {
        logic        c0;
        logic [31:0] a0;
        logic        c1;
        logic [31:0] a1;
        logic        sack;
        logic [1:0]  e_g;
        logic        e_cyc;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_adr;
        logic        e_ack0;
        logic        e_ack1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c0, input logic [31:0] a0, input logic c1,
                                input logic [31:0] a1, input logic sack, input logic [1:0] g,
                                input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic ack0, input logic ack1);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1; v.sack = sack;
        v.e_g = g; v.e_cyc = cyc; v.e_stb = stb; v.e_we = we; v.e_adr = adr;
        v.e_ack0 = ack0; v.e_ack1 = ack1;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // m0 always writes (WE=1), m1 always reads (WE=0); DAT_O mirrors ADR.
    task automatic drive(input logic c0, input logic [31:0] a0, input logic c1,
                         input logic [31:0] a1, input logic sack);
        m0_cyc = c0; m0_stb = c0; m0_we = 1'b1; m0_adr = a0; m0_dat_o = a0;
        m1_cyc = c1; m1_stb = c1; m1_we = 1'b0; m1_adr = a1; m1_dat_o = a1;
        s_ack  = sack;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int fire_k;
        logic seen_to;
        logic all_cyc;

        rst = 1'b1;
        drive(1'b1, 32'd5, 1'b1, 32'd6, 1'b1);
        s_dat_i = 32'h1234_5678;
        #12;
        check("reset_state",
              {grant, s_cyc, s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, timeout, arb_state},
              {2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;

        // Contended alternation straight from reset: m0, m1, m0, m1, m0, m1.
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b00, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b01, 1, 1, 1, 10, 1, 0));
        vecs.push_back(mk(0, 10, 1, 20, 0, 2'b01, 0, 0, 1, 10, 0, 0));
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b10, 1, 1, 0, 20, 0, 1));
        vecs.push_back(mk(1, 10, 0, 20, 0, 2'b10, 0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b01, 1, 1, 1, 10, 1, 0));
        vecs.push_back(mk(0, 10, 1, 20, 0, 2'b01, 0, 0, 1, 10, 0, 0));
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b10, 1, 1, 0, 20, 0, 1));
        vecs.push_back(mk(1, 10, 0, 20, 0, 2'b10, 0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(1, 10, 1, 20, 1, 2'b01, 1, 1, 1, 10, 1, 0));
        vecs.push_back(mk(0, 10, 1, 20, 0, 2'b01, 0, 0, 1, 10, 0, 0));
        vecs.push_back(mk(0, 10, 1, 20, 1, 2'b10, 1, 1, 0, 20, 0, 1));
        vecs.push_back(mk(0, 10, 0, 20, 0, 2'b10, 0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0,  0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0));
        // m1 waits behind an m0 burst and takes over the cycle after m0 drops CYC.
        vecs.push_back(mk(1, 41, 0, 77, 0, 2'b00, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 41, 1, 77, 1, 2'b01, 1, 1, 1, 41, 1, 0));
        vecs.push_back(mk(1, 41, 1, 77, 1, 2'b01, 1, 1, 1, 41, 1, 0));
        vecs.push_back(mk(1, 41, 1, 77, 1, 2'b01, 1, 1, 1, 41, 1, 0));
        vecs.push_back(mk(1, 41, 1, 77, 1, 2'b01, 1, 1, 1, 41, 1, 0));
        vecs.push_back(mk(0, 41, 1, 77, 0, 2'b01, 0, 0, 1, 41, 0, 0));
        vecs.push_back(mk(0, 41, 1, 77, 1, 2'b10, 1, 1, 0, 77, 0, 1));
        vecs.push_back(mk(0, 41, 0, 77, 0, 2'b10, 0, 0, 0, 77, 0, 0));
        vecs.push_back(mk(0,  0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0));
        // Single m0 write, slave ACKs on the third granted cycle.
        vecs.push_back(mk(1, 41, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 41, 0,  0, 0, 2'b01, 1, 1, 1, 41, 0, 0));
        vecs.push_back(mk(1, 41, 0,  0, 0, 2'b01, 1, 1, 1, 41, 0, 0));
        vecs.push_back(mk(1, 41, 0,  0, 1, 2'b01, 1, 1, 1, 41, 1, 0));
        vecs.push_back(mk(0,  0, 0,  0, 0, 2'b01, 0, 0, 1,  0, 0, 0));
        vecs.push_back(mk(0,  0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] dat;
            @(negedge clk);
            dat = 32'hC0DE_0000 | 32'(i);
            drive(vecs[i].c0, vecs[i].a0, vecs[i].c1, vecs[i].a1, vecs[i].sack);
            s_dat_i = dat;
            #1;
            check($sformatf("vec%0d", i),
                  {grant, s_cyc, s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, timeout,
                   m0_dat_i, m1_dat_i},
                  {vecs[i].e_g, vecs[i].e_cyc, vecs[i].e_stb, vecs[i].e_we, vecs[i].e_adr,
                   vecs[i].e_adr, vecs[i].e_ack0, vecs[i].e_ack1, 1'b0, dat, dat});
        end

        // Slave never ACKs: counter is 0 in granted cycle 1, so it equals 8 in cycle 9.
        @(negedge clk);
        drive(1'b1, 32'd41, 1'b0, 32'd0, 1'b0);
        s_dat_i = 32'hDEAD_BEEF;
        fire_k  = 0;
        all_cyc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            #1;
            if (timeout) begin
                fire_k = k;
                break;
            end
            all_cyc = all_cyc & s_cyc;
        end
        check("timeout_cycle", 160'(fire_k), 160'(9));
        check("timeout_abort",
              {grant, s_cyc, s_stb, m0_ack, m1_ack, m0_dat_i, all_cyc},
              {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1});
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        check("timeout_single_pulse", {timeout, grant, m0_dat_i}, {1'b0, 2'b01, 32'hDEAD_BEEF});
        @(negedge clk);
        #1;
        check("timeout_release", {grant, timeout}, {2'b00, 1'b0});

        // Slave ACKs in the very cycle the counter reaches the limit: real ACK wins.
        @(negedge clk);
        drive(1'b1, 32'd41, 1'b0, 32'd0, 1'b0);
        seen_to = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            seen_to = seen_to | timeout;
        end
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        check("ack_at_limit",
              {seen_to, timeout, m0_ack, m0_dat_i, s_cyc, s_stb},
              {1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1});
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        #1;
        check("ack_at_limit_after", {timeout, m0_ack}, {1'b0, 1'b0});
        @(negedge clk);

        // Asynchronous reset in the middle of an m1 transfer.
        drive(1'b0, 32'd0, 1'b1, 32'd99, 1'b0);
        m1_we = 1'b1;
        @(negedge clk);
        #1;
        check("pre_reset_m1_owner", {grant, s_cyc, s_stb, s_we, s_adr}, {2'b10, 1'b1, 1'b1, 1'b1, 32'd99});
        #1;
        rst   = 1'b1;
        s_ack = 1'b1;
        #1;
        check("async_reset_outputs",
              {grant, s_cyc, s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, timeout, arb_state},
              {2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'd1, 1'b1, 32'd2, 1'b0);
        #1;
        check("post_reset_idle", grant, 2'b00);
        @(negedge clk);
        #1;
        check("post_reset_tie_m0", {grant, s_adr}, {2'b01, 32'd1});
        @(negedge clk);
        drive(1'b0, 32'd1, 1'b1, 32'd2, 1'b0);
        #1;
        @(negedge clk);
        #1;
        check("post_reset_next_m1", {grant, s_adr}, {2'b10, 32'd2});
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone B4 arbiter that shares one slave port between the core's memory-side requesters (the instruction fetch unit on `m0` and the load/store unit or console/debug test master on `m1`). It holds a grant for the full duration of a master's `CYC`, alternates fairly between masters, and routes the granted master's signals to the slave. A bus watchdog terminates any access the slave never acknowledges, so a dead peripheral cannot hang the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a strobed access may wait for `ACK` before the watchdog fires. 0 disables the watchdog.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0` WB4.slave: master 0 port (`CYC`, `STB`, `WE`, `ADR[31:0]`, `DAT_O[31:0]` in; `DAT_I[31:0]`, `ACK` out). Higher priority after reset.
- `m1` WB4.slave: master 1 port, same signals as `m0`.
- `s` WB4.master: shared slave port.
- `grant` out 2: one-hot current owner (`01` = m0, `10` = m1, `00` = idle).
- `timeout` out 1: one-cycle pulse when the watchdog terminates an access.

## Operation
- States: `ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`. State, `last` (last granted master) and the watchdog counter are the only registers.
- A master requests when its `CYC` is high.
- `ARB_IDLE` transitions:
  - only m0 requests: go to `GNT0`.
  - only m1 requests: go to `GNT1`.
  - both request: grant the master that is not `last`.
  - no request: stay idle.
- `ARB_GNTx`:
  - stay while `mx.CYC` is high.
  - when `mx.CYC` drops, arbitrate immediately with the `ARB_IDLE` rules, so the other master gets a back-to-back grant with no idle cycle.
  - set `last` = x on entering `GNTx`.
- Output muxing is combinational from state.
  - `s.CYC`/`STB`/`WE`/`ADR`/`DAT_O` = granted master's signals; all 0 when idle.
  - `mx.ACK` = `s.ACK` only when x is granted, else 0.
  - `s.DAT_I` is broadcast to both masters' `DAT_I`.
- Watchdog:
  - counter increments each cycle in `GNTx` with `s.STB`=1 and `s.ACK`=0.
  - clears on `s.ACK`, on leaving `GNTx`, or when it fires.
  - fires when counter == `TIMEOUT_CYCLES`. That cycle: `s.CYC`/`s.STB` forced 0, synthetic `mx.ACK`=1 with `mx.DAT_I`=32'h0, and `timeout`=1.
  - grant is kept after firing; the master decides whether to retry.
- Width rule: counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates (never wraps).
- Reset values (asynchronous, any time including mid-transfer):
  - state `ARB_IDLE`, `last`=m1 (so m0 wins the first tie), counter 0.
  - `s.CYC`/`STB`/`WE`=0, `s.ADR`=0, `s.DAT_O`=0, both `ACK`=0, `grant`=00, `timeout`=0.
  - An aborted transfer is not resumed.

## Timing
- Grant latency: one cycle. `CYC` is sampled at edge N; `s.CYC` is high in cycle N+1.
- `ACK`/`DAT_I` path slave-to-master is combinational, zero added latency.
- Hand-over: m0 drops `CYC` before edge N while m1 requests. m1 drives `s` from cycle N+1.
- Simultaneous first requests from reset: m0 granted. The next contended arbitration goes to m1.
- `ACK` in the same cycle the counter reaches `TIMEOUT_CYCLES`: the real `ACK` wins. No timeout, no synthetic `ACK`.
- A master raising `CYC` while not granted waits with `ACK`=0. Its `STB` is never forwarded.

## Structure
- Package `wb_arb_pkg`: `arb_state_t` enum (`ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`) and `TIMEOUT_DATA` = 32'h0.
- Sub-module `wb_watchdog` (params `TIMEOUT_CYCLES`; inputs `clk`, `rst`, `active`, `ack`; output `fire`). The arbiter holds FSM and muxing.

## Test plan
- Single m0 write (ADR=41, DAT_O=41) with a slave ACKing after 2 cycles: `s` sees ADR=41/DAT_O=41/WE=1 one cycle after `CYC`, `m0.ACK` is 1 for one cycle, `grant`=01, `m1.ACK` stays 0.
- Both masters raise `CYC` in the same cycle after reset, each doing 3 back-to-back requests: grants alternate m0, m1, m0, m1, m0, m1 with no idle cycle between owners.
- m1 requests while m0 holds a 5-cycle `CYC` burst: m1 waits exactly until m0 drops `CYC`, then `s` shows m1's ADR the next cycle, and no m1 `STB` leaks during m0's burst.
- `TIMEOUT_CYCLES`=8 with a slave that never ACKs: after 8 strobed cycles, `timeout` pulses once, `m0.ACK`=1 with `DAT_I`=0, and `s.CYC` is 0 that cycle. Repeat with the slave ACKing exactly on cycle 8: no timeout.
- Assert `rst` mid-transfer (m1 granted, `STB` high): all `s` outputs and `grant` go to 0 immediately without a clock. After release, a simultaneous request is granted to m0.
